// File: rtl/ahb_lite_sram_slave.sv
// ============================================================================
//  Module   : ahb_lite_sram_slave
//  Purpose  : AHB-Lite slave responder backed by an internal word-addressed
//             SRAM array. Supports byte-lane writes by HSIZE, configurable
//             wait states, address/data-phase pipelining and the two-cycle
//             ERROR response for out-of-range, oversize or misaligned
//             transfers.
//  Options  : `define AHB_SLV_PRIV_PROT_EN to reject user-mode (HPROT[1]=0)
//             accesses to the upper quarter of the memory.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_lite_sram_slave #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MEM_DEPTH   = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic                  HMASTLOCK,
    input  logic                  HREADY,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int          BYTES     = DATA_WIDTH / 8;
    localparam int          ADDR_LSB  = $clog2(BYTES);
    localparam int          IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [63:0] MEM_BYTES = 64'(MEM_DEPTH) * 64'(BYTES);
    localparam logic        HAS_WAIT  = (WAIT_STATES > 0);
    localparam logic [2:0]  WAIT_LOAD = HAS_WAIT ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    // Storage and data-phase context captured at acceptance
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    state_t                state;
    logic [2:0]            wait_cnt;
    logic                  ready_q;
    logic                  resp_q;
    logic                  write_q;
    logic [2:0]            size_q;
    logic [ADDR_LSB-1:0]   lane_q;
    logic [IDX_W-1:0]      idx_q;

    // Address-phase decode
    logic                  accept;
    logic [ADDR_WIDTH-1:0] offset;
    logic [63:0]           offset_ext;
    logic [IDX_W-1:0]      word_idx;
    logic                  below_base;
    logic                  above_top;
    logic                  size_err;
    logic [2:0]            align_mask;
    logic                  misalign;
    logic                  prot_err;
    logic                  xfer_err;
    logic [BYTES-1:0]      byte_en;

    assign accept     = HSEL & HREADY & HTRANS[1];
    assign offset     = HADDR - BASE_ADDR;
    assign offset_ext = 64'(offset);
    assign word_idx   = offset[ADDR_LSB +: IDX_W];
    assign below_base = (HADDR < BASE_ADDR);
    assign above_top  = (offset_ext >= MEM_BYTES);
    assign size_err   = (HSIZE > 3'(ADDR_LSB));

    // Low-address bits that must be zero for the requested transfer size
    always_comb begin
        align_mask = 3'b111;
        case (HSIZE)
            3'd0:    align_mask = 3'b000;
            3'd1:    align_mask = 3'b001;
            3'd2:    align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
    end

    assign misalign = |(HADDR[2:0] & align_mask);

`ifdef AHB_SLV_PRIV_PROT_EN
    localparam logic [IDX_W:0] PRIV_IDX = (IDX_W+1)'((3 * MEM_DEPTH) / 4);

    // User-mode access into the privileged top quarter is refused
    assign prot_err = ~HPROT[1] & ({1'b0, word_idx} >= PRIV_IDX);

    logic unused_inputs;
    assign unused_inputs = ^{HBURST, HMASTLOCK, HTRANS[0], HPROT[3:2], HPROT[0]};
`else
    assign prot_err = 1'b0;

    logic unused_inputs;
    assign unused_inputs = ^{HBURST, HMASTLOCK, HTRANS[0], HPROT};
`endif

    assign xfer_err = below_base | above_top | size_err | misalign | prot_err;

    // Transfer FSM: state, wait counter, registered response and phase context
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state    <= ST_IDLE;
            wait_cnt <= 3'd0;
            ready_q  <= 1'b1;
            resp_q   <= 1'b0;
            write_q  <= 1'b0;
            size_q   <= 3'd0;
            lane_q   <= '0;
            idx_q    <= '0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state   <= ST_DATA;
                        ready_q <= 1'b1;
                        resp_q  <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                ST_ERR1: begin
                    // Second ERROR cycle always follows; the bus is stalled
                    state   <= ST_ERR2;
                    ready_q <= 1'b1;
                    resp_q  <= 1'b1;
                end
                default: begin
                    // IDLE, DATA and ERR2 are all points where a new
                    // address phase can be taken
                    if (accept) begin
                        write_q <= HWRITE & ~xfer_err;
                        size_q  <= HSIZE;
                        lane_q  <= HADDR[ADDR_LSB-1:0];
                        idx_q   <= word_idx;
                        if (xfer_err) begin
                            state   <= ST_ERR1;
                            ready_q <= 1'b0;
                            resp_q  <= 1'b1;
                        end else if (HAS_WAIT) begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_LOAD;
                            ready_q  <= 1'b0;
                            resp_q   <= 1'b0;
                        end else begin
                            state   <= ST_DATA;
                            ready_q <= 1'b1;
                            resp_q  <= 1'b0;
                        end
                    end else begin
                        state   <= ST_IDLE;
                        ready_q <= 1'b1;
                        resp_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Byte lanes touched by the current data phase
    always_comb begin
        byte_en = '0;
        for (int i = 0; i < BYTES; i++) begin
            if ((i >= int'(lane_q)) && (i < int'(lane_q) + (1 << size_q))) begin
                byte_en[i] = 1'b1;
            end
        end
    end

    // Commit write lanes at the edge that closes the DATA cycle
    always_ff @(posedge HCLK) begin
        if ((state == ST_DATA) && write_q) begin
            for (int i = 0; i < BYTES; i++) begin
                if (byte_en[i]) begin
                    mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    assign HRDATA    = ((state == ST_DATA) && !write_q) ? mem[idx_q] : '0;
    assign HREADYOUT = ready_q;
    assign HRESP     = resp_q;

endmodule

`default_nettype wire

// File: doc/ahb_lite_sram_slave.md
Name: ahb_lite_sram_slave

Overview:
Parametrised AHB-Lite slave responder backed by an internal word-addressed SRAM array. It is the reactive counterpart to the AHB-Lite interface used by the VIP, and serves as the DUT-side target for agent and scoreboard bring-up. Compared with a fixed-width pin bundle, it generalises to configurable address/data width, memory depth, base address and wait states. It also adds byte-lane writes by HSIZE, address/data-phase pipelining and the two-cycle ERROR response.

Parameters:
ADDR_WIDTH, 32, HADDR width
DATA_WIDTH, 32, HWDATA/HRDATA width; legal 32 or 64
MEM_DEPTH, 1024, number of DATA_WIDTH-bit words
BASE_ADDR, 0, byte address of word 0; aligned to DATA_WIDTH/8
WAIT_STATES, 0, wait cycles inserted per OKAY data phase; legal 0..7

Ports:
HCLK  in  1  clock; all logic on rising edge
HRESET  in  1  reset; asynchronous assert, active-high
HSEL  in  1  slave select
HADDR  in  ADDR_WIDTH  byte address
HTRANS  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
HWRITE  in  1  1 = write
HSIZE  in  3  transfer size, 2^HSIZE bytes
HBURST  in  3  burst type; informational only
HPROT  in  4  protection; used only by the optional feature
HMASTLOCK  in  1  ignored
HREADY  in  1  bus-level ready (mux output)
HWDATA  in  DATA_WIDTH  write data
HRDATA  out  DATA_WIDTH  read data
HREADYOUT  out  1  slave ready
HRESP  out  1  0 OKAY, 1 ERROR

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. HCLK is the clock; HRESET is the reset.
- Reset: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0. Memory contents are not cleared.
- Reset asserted mid-transfer aborts the transfer. No memory write occurs.
- Accept condition: HSEL & HREADY & HTRANS[1]. On acceptance, register HADDR, HWRITE and HSIZE; the data phase starts next cycle.
- IDLE or BUSY with HSEL, and any unselected cycle: no data phase is opened; zero-wait OKAY response.
- Error check at acceptance. Any of the following makes the transfer an error:
  - (HADDR-BASE_ADDR) >= MEM_DEPTH*DATA_WIDTH/8
  - HADDR < BASE_ADDR
  - 2^HSIZE > DATA_WIDTH/8
  - HADDR not aligned to 2^HSIZE
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE/DATA/ERR2 --accept & ok & WAIT_STATES>0--> WAIT (counter loads WAIT_STATES-1)
  - IDLE/DATA/ERR2 --accept & ok & WAIT_STATES=0--> DATA
  - IDLE/DATA/ERR2 --accept & error--> ERR1
  - IDLE/DATA/ERR2 --no accept--> IDLE
  - WAIT: HREADYOUT=0, HRESP=0; decrement counter; at 0 go to DATA.
  - DATA: HREADYOUT=1, HRESP=0; last data-phase cycle, so the next address phase may be accepted in the same cycle.
  - ERR1: HREADYOUT=0, HRESP=1; always goes to ERR2; address-phase inputs ignored.
  - ERR2: HREADYOUT=1, HRESP=1; may accept the next transfer.
- Write: in DATA, HWDATA bytes selected by registered addr[log2(DATA_WIDTH/8)-1:0] and size are committed at the clock edge ending DATA. Other byte lanes are unchanged.
- Read: in DATA, HRDATA = full word mem[(addr-BASE_ADDR)>>log2(DATA_WIDTH/8)]. HRDATA=0 in all other states.
- Erroring transfers never modify memory.
- Back-to-back write then read to the same word: the read returns the newly written bytes.
- WAIT_STATES=0: sustained throughput of one transfer per cycle.
- Error transfers: exactly 2 cycles, independent of WAIT_STATES.
- Master abandoning a burst with IDLE after ERR2: no data phase follows.

Optional Feature:
- Macro: AHB_SLV_PRIV_PROT_EN.
- Defined: an accepted transfer with HPROT[1]=0 (user mode) and a word index in the upper quarter of memory (index >= 3*MEM_DEPTH/4) is treated as an error: ERR1/ERR2 sequence, no write.
- Undefined: HPROT is ignored entirely, with no extra logic.

Test Plan:
- Reset mid-WAIT with WAIT_STATES=3 and a write to 0x10 outstanding -> outputs return to reset values asynchronously; a later read of 0x10 does not return the aborted data.
- WAIT_STATES=0, NONSEQ write 0xDEADBEEF to 0x04, then NONSEQ read 0x04 in the next cycle -> read data phase shows HRDATA=0xDEADBEEF, HREADYOUT=1, HRESP=0, with no gap cycles.
- Word 0x08 preloaded with 0x11223344; byte write HSIZE=0 to 0x09 with HWDATA=0x0000AA00 -> read of 0x08 returns 0x1122AA44.
- WAIT_STATES=2, single read -> HREADYOUT low for exactly 2 cycles, then high with valid data.
- Read to BASE_ADDR+MEM_DEPTH*4 -> cycle 1: HREADYOUT=0, HRESP=1; cycle 2: HREADYOUT=1, HRESP=1. Also: misaligned HSIZE=2 access at 0x02 -> same ERROR sequence; memory unchanged.
- 4-beat INCR write burst with a BUSY inserted after beat 2 -> BUSY gets a zero-wait OKAY; all 4 words are written. With AHB_SLV_PRIV_PROT_EN, a user-mode write to word 900 (MEM_DEPTH=1024) -> ERROR; word 900 unchanged.
